// File: rtl/peripheral_apb4_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : peripheral_apb4_pkg                                             |
// | Brief    : Shared FSM state and response types for the APB4 requester.     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package peripheral_apb4_pkg;

    localparam int unsigned c_APB4_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb4_state_t;

    typedef struct packed {
        logic [c_APB4_DATA_W-1:0] rdata;
        logic                     err;
        logic                     timeout;
    } apb4_rsp_t;

endpackage

`default_nettype wire

// File: rtl/peripheral_apb4_watchdog.sv
// +----------------------------------------------------------------------------+
// | Module   : peripheral_apb4_watchdog                                        |
// | Brief    : Saturating wait-state counter that flags a stalled ACCESS phase. |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module peripheral_apb4_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != {TMO_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry fires on the last permitted wait cycle so the abort lands on that edge.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_wd_off
            assign expired = 1'b0;
        end else begin : g_wd_on
            localparam logic [TMO_W-1:0] c_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);
            assign expired = (r_count == c_LIMIT);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/peripheral_apb4_master.sv
// +----------------------------------------------------------------------------+
// | Module   : peripheral_apb4_master                                          |
// | Brief    : APB4 requester bridging a valid/ready command/response channel.  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module peripheral_apb4_master
    import peripheral_apb4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = c_APB4_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb4_state_t r_state;
    apb4_rsp_t   r_rsp;
    logic        w_wd_clr;
    logic        w_wd_en;
    logic        w_wd_expired;

    assign w_wd_clr = (r_state == SETUP);
    assign w_wd_en  = (r_state == ACCESS) && !PREADY;

    peripheral_apb4_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (PCLK),
        .rst     (PRESET),
        .clr     (w_wd_clr),
        .en      (w_wd_en),
        .expired (w_wd_expired)
    );

    always_comb begin
        cmd_ready = (r_state == IDLE) && !rsp_valid;
    end

    assign rsp_rdata   = DATA_WIDTH'(r_rsp.rdata);
    assign rsp_err     = r_rsp.err;
    assign rsp_timeout = r_rsp.timeout;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            r_rsp     <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_addr[1:0] != 2'b00) begin
                            // Misaligned requests never reach the bus.
                            rsp_valid     <= 1'b1;
                            r_rsp.rdata   <= '0;
                            r_rsp.err     <= 1'b1;
                            r_rsp.timeout <= 1'b0;
                        end else begin
                            PADDR   <= cmd_addr;
                            PWRITE  <= cmd_write;
                            PWDATA  <= cmd_wdata;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        r_rsp.err     <= PSLVERR;
                        r_rsp.timeout <= 1'b0;
                        r_rsp.rdata   <= (!PWRITE && !PSLVERR) ? c_APB4_DATA_W'(PRDATA) : '0;
                        r_state       <= IDLE;
                    end else if (w_wd_expired) begin
                        PSEL          <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_valid     <= 1'b1;
                        r_rsp.err     <= 1'b1;
                        r_rsp.timeout <= 1'b1;
                        r_rsp.rdata   <= '0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_peripheral_apb4_master.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_peripheral_apb4_master                                       |
// | Brief    : Randomized self-checking bench for the APB4 requester.           |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_peripheral_apb4_master;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_paddr;
    logic [31:0] exp_pwdata;
    logic        exp_pwrite;

    peripheral_apb4_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK        (clk),
        .PRESET      (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, play the slave with 'waits' wait states, then hold the
    // response for 'hold' cycles before consuming it. Expectations come from the
    // transfer rules: misaligned -> immediate error, waits >= TMO -> watchdog abort.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic slverr, input logic [31:0] prd,
                           input int hold);
        logic        mis;
        int          exp_lat;
        logic        exp_err;
        logic        exp_tmo;
        logic [31:0] exp_rd;
        int          lat;
        int          nsel;
        int          nen;
        int          acc;
        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            exp_lat = 0; exp_err = 1'b1; exp_tmo = 1'b0; exp_rd = '0;
        end else if (waits >= TMO) begin
            exp_lat = 1 + TMO; exp_err = 1'b1; exp_tmo = 1'b1; exp_rd = '0;
        end else begin
            exp_lat = 2 + waits; exp_err = slverr; exp_tmo = 1'b0;
            exp_rd  = (!wr && !slverr) ? prd : 32'h0;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        if (!mis) begin
            exp_paddr = addr; exp_pwdata = wdata; exp_pwrite = wr;
        end
        lat = 0; nsel = 0; nen = 0; acc = 0;
        while (!rsp_valid && lat < 50) begin
            if (PSEL) begin
                nsel++;
                chk("paddr_stable", PADDR, addr);
                chk("pwrite", PWRITE, wr);
                chk("pwdata", PWDATA, wdata);
            end
            if (PSEL && PENABLE) begin
                nen++;
                PREADY  = (acc == waits);
                PSLVERR = (acc == waits) ? slverr : 1'($urandom);
                PRDATA  = (acc == waits) ? prd : $urandom;
                acc++;
            end else begin
                PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
        chk("latency", lat, exp_lat);
        chk("psel_cycles", nsel, mis ? 0 : exp_lat);
        chk("penable_cycles", nen, mis ? 0 : exp_lat - 1);
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_timeout", rsp_timeout, exp_tmo);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            chk("psel_idle", PSEL, 0);
            chk("penable_idle", PENABLE, 0);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("paddr_kept", PADDR, exp_paddr);
            chk("pwdata_kept", PWDATA, exp_pwdata);
            if (i == hold) begin
                rsp_ready = 1'b1;
            end else begin
                cmd_valid = 1'b1; cmd_addr = $urandom; cmd_write = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
        chk("cmd_ready_after", cmd_ready, 1);
    endtask

    initial begin
        logic [31:0] a;
        n_checks = 0; n_errors = 0;
        exp_paddr = '0; exp_pwdata = '0; exp_pwrite = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_bits", {rsp_err, rsp_timeout, rsp_rdata}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 1);

        run_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 0);
        run_cmd(1'b0, 32'h0000_0024, 32'h0, 3, 1'b0, 32'h1234_5678, 0);
        run_cmd(1'b0, 32'h0000_0030, 32'h0, 1, 1'b1, 32'hCAFE_F00D, 0);
        run_cmd(1'b0, 32'h0000_0040, 32'h0, 100, 1'b0, 32'h5555_AAAA, 0);
        run_cmd(1'b1, 32'h0000_0013, 32'h0BAD_0BAD, 0, 1'b0, 32'h0, 0);
        run_cmd(1'b0, 32'h0000_0050, 32'h0, 0, 1'b0, 32'h8765_4321, 10);
        run_cmd(1'b1, 32'h0000_0060, 32'h1111_2222, TMO - 1, 1'b0, 32'h0, 1);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            else a[1:0] = 2'($urandom_range(1, 3));
            run_cmd(1'($urandom), a, $urandom, $urandom_range(0, 6),
                    ($urandom_range(0, 4) == 0), $urandom, $urandom_range(0, 3));
        end

        // Reset while in ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0080;
        @(posedge clk); #1;
        cmd_valid = 1'b0; PREADY = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_psel", PSEL, 0);
        chk("rst_mid_penable", PENABLE, 0);
        chk("rst_mid_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_paddr = '0; exp_pwdata = '0;

        // Reset discards a pending response.
        cmd_valid = 1'b1; cmd_addr = 32'h0000_0101;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("pend_rsp_valid", rsp_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("pend_rsp_dropped", rsp_valid, 0);
        chk("pend_rsp_err", rsp_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_cmd(1'b0, 32'h0000_0084, 32'h0, 2, 1'b0, 32'hA5A5_5A5A, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
